uart_rx_ctrl: RTL and testbench

Receive-side control stage of the UART RX. Consumes the edge/bit counter outputs (`edge_count`, `bit_count`, `edge_count_done`) and drives their enables back. It also contains the majority-vote data sampler, the LSB-first deserializer, and the parity and stop checks. It hands each good byte to the RX synchronizer/register-file path as `P_DATA` with a one-cycle `data_valid` pulse.

---
 rtl/uart_rx_ctrl_if.sv | 32 +++
 rtl/uart_rx_ctrl.sv | 123 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX control stage and its edge/bit counters,
// line input, config bits and the downstream byte sink.
interface uart_rx_ctrl_if #(
    parameter int PRESCALE_WD = 6,
    parameter int BIT_CNT_WD  = 4,
    parameter int DATA_WD     = 8
);
    logic                   RX_IN;
    logic                   PAR_EN;
    logic                   PAR_TYP;
    logic [PRESCALE_WD-1:0] prescale;
    logic [PRESCALE_WD-1:0] edge_count;
    logic [BIT_CNT_WD-1:0]  bit_count;
    logic                   edge_count_done;
    logic                   edge_cnt_en;
    logic                   bit_cnt_en;
    logic [DATA_WD-1:0]     P_DATA;
    logic                   data_valid;
    logic                   par_err;
    logic                   stp_err;
    logic                   strt_glitch;

    modport master (
        input  RX_IN, PAR_EN, PAR_TYP, prescale, edge_count, bit_count, edge_count_done,
        output edge_cnt_en, bit_cnt_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
    );

    modport slave (
        output RX_IN, PAR_EN, PAR_TYP, prescale, edge_count, bit_count, edge_count_done,
        input  edge_cnt_en, bit_cnt_en, P_DATA, data_valid, par_err, stp_err, strt_glitch
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX control: frame FSM, 3-point majority sampler, LSB-first deserializer,
// parity/stop checking, and registered one-cycle result pulses.
module uart_rx_ctrl #(
    parameter int PRESCALE_WD = 6,
    parameter int BIT_CNT_WD  = 4,
    parameter int DATA_WD     = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic [PRESCALE_WD-1:0] half;
    logic [2:0]           smp;
    logic                 sampled;
    logic                 latch_cfg, shift_en, par_chk, stop_chk, glitch;
    logic                 par_en_l, par_typ_l, par_mis;
    logic [DATA_WD-1:0]   shreg, pdata_q;
    logic                 dv_q, perr_q, serr_q, glitch_q;

    assign half    = bus.prescale >> 1;
    assign sampled = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    // Samples at P/2-1, P/2, P/2+1; the vote is stable from P/2+2 onwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (bus.edge_count == half + PRESCALE_WD'(i) - PRESCALE_WD'(1))
                    smp[i] <= bus.RX_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_cfg = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        stop_chk  = 1'b0;
        glitch    = 1'b0;
        case (state)
            IDLE: if (!bus.RX_IN) begin
                state_nxt = START;
                latch_cfg = 1'b1;
            end
            START: if (bus.edge_count_done) begin
                if (sampled) begin
                    glitch    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DATA;
                end
            end
            DATA: if (bus.edge_count_done) begin
                shift_en = 1'b1;
                if (bus.bit_count == BIT_CNT_WD'(DATA_WD))
                    state_nxt = par_en_l ? PARITY : STOP;
            end
            PARITY: if (bus.edge_count_done) begin
                par_chk   = 1'b1;
                state_nxt = STOP;
            end
            STOP: if (bus.edge_count_done) begin
                stop_chk  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_mis   <= 1'b0;
            shreg     <= '0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            glitch_q  <= 1'b0;
        end else begin
            dv_q     <= 1'b0;
            perr_q   <= 1'b0;
            serr_q   <= 1'b0;
            glitch_q <= glitch;
            if (latch_cfg) begin
                par_en_l  <= bus.PAR_EN;
                par_typ_l <= bus.PAR_TYP;
                par_mis   <= 1'b0;
            end
            if (shift_en)
                shreg <= {sampled, shreg[DATA_WD-1:1]};
            if (par_chk)
                par_mis <= sampled != (^shreg ^ par_typ_l);
            // Parity mismatch only counts when parity was enabled for this frame.
            if (stop_chk) begin
                serr_q <= ~sampled;
                perr_q <= par_en_l & par_mis;
                if (sampled && !(par_en_l && par_mis)) begin
                    pdata_q <= shreg;
                    dv_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.edge_cnt_en = (state != IDLE);
    assign bus.bit_cnt_en  = (state != IDLE);
    assign bus.P_DATA      = pdata_q;
    assign bus.data_valid  = dv_q;
    assign bus.par_err     = perr_q;
    assign bus.stp_err     = serr_q;
    assign bus.strt_glitch = glitch_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: counter model, serial line driver, and a scoreboard
// of expected result pulses (content, P_DATA and arrival cycle).
module tb_uart_rx_ctrl;
    localparam int PW  = 6;
    localparam int BW  = 4;
    localparam int DW  = 8;
    localparam int BIG = 1 << 30;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    uart_rx_ctrl_if #(.PRESCALE_WD(PW), .BIT_CNT_WD(BW), .DATA_WD(DW)) bus();
    uart_rx_ctrl #(.PRESCALE_WD(PW), .BIT_CNT_WD(BW), .DATA_WD(DW)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Edge/bit counter behaving per the counter contract.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.edge_count <= '0;
            bus.bit_count  <= '0;
        end else begin
            if (!bus.edge_cnt_en)                          bus.edge_count <= '0;
            else if (bus.edge_count == bus.prescale - 6'd1) bus.edge_count <= '0;
            else                                            bus.edge_count <= bus.edge_count + 6'd1;
            if (!bus.bit_cnt_en)                           bus.bit_count <= '0;
            else if (bus.edge_count == bus.prescale - 6'd1) bus.bit_count <= bus.bit_count + 4'd1;
        end
    end
    assign bus.edge_count_done = (bus.edge_count == bus.prescale - 6'd1);

    typedef struct {
        logic [7:0] pdata;
        bit dv, pe, se, sg;
        int cyc;
    } exp_t;

    typedef struct {
        int p;
        bit pe, pt;
        logic [7:0] d;
        bit pb, stp;
        bit dv, perr, serr;
        logic [7:0] pdata;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[9];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit dv, input bit pe, input bit se, input bit sg,
                            input logic [7:0] pd, input int at);
        exp_t e;
        e.dv = dv; e.pe = pe; e.se = se; e.sg = sg; e.pdata = pd; e.cyc = at;
        sb.push_back(e);
    endtask

    // Any pulse pops the next expected result and must match it exactly.
    always @(negedge CLK) begin
        if (!RST && (bus.data_valid || bus.par_err || bus.stp_err || bus.strt_glitch)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b sg=%b at cycle %0d, none expected",
                         bus.data_valid, bus.par_err, bus.stp_err, bus.strt_glitch, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("data_valid",  int'(bus.data_valid),  int'(mon_e.dv));
                chk("par_err",     int'(bus.par_err),     int'(mon_e.pe));
                chk("stp_err",     int'(bus.stp_err),     int'(mon_e.se));
                chk("strt_glitch", int'(bus.strt_glitch), int'(mon_e.sg));
                chk("P_DATA",      int'(bus.P_DATA),      int'(mon_e.pdata));
                chk("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d expected pulses never arrived, required 0 pending", name, sb.size());
            sb.delete();
        end
    endtask

    // Drives one frame on the line from the current negedge; stops early after
    // stop_after cycles. Config inputs are scrambled mid-frame to prove latching.
    task automatic drive_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                               input bit pb, input bit stp, input int stop_after);
        logic [10:0] bits;
        int nb, n;
        if (pe) begin bits = {stp, pb, d, 1'b0};        nb = 11; end
        else    begin bits = {1'b1, stp, d, 1'b0};      nb = 10; end
        bus.prescale = PW'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        n = 0;
        for (int k = 0; k < nb; k++) begin
            for (int j = 0; j < p; j++) begin
                if (n == stop_after) return;
                bus.RX_IN = bits[k];
                @(negedge CLK);
                n++;
                if (n == 2) begin
                    bus.PAR_EN  = ~pe;
                    bus.PAR_TYP = ~pt;
                end
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_valid"},  int'(bus.data_valid),  0);
        chk({tag, "_par_err"},     int'(bus.par_err),     0);
        chk({tag, "_stp_err"},     int'(bus.stp_err),     0);
        chk({tag, "_strt_glitch"}, int'(bus.strt_glitch), 0);
        chk({tag, "_P_DATA"},      int'(bus.P_DATA),      0);
        chk({tag, "_edge_cnt_en"}, int'(bus.edge_cnt_en), 0);
        chk({tag, "_bit_cnt_en"},  int'(bus.bit_cnt_en),  0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        vt[0] = '{8,  0, 0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5};
        vt[1] = '{16, 1, 0, 8'h3C, 0, 1, 1, 0, 0, 8'h3C};
        vt[2] = '{16, 1, 0, 8'h3C, 1, 1, 0, 1, 0, 8'h3C};
        vt[3] = '{32, 1, 1, 8'h01, 0, 0, 0, 0, 1, 8'h3C};
        vt[4] = '{16, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};
        vt[5] = '{8,  1, 1, 8'hFF, 1, 1, 1, 0, 0, 8'hFF};
        vt[6] = '{8,  1, 0, 8'h0F, 1, 0, 0, 1, 1, 8'hFF};
        vt[7] = '{32, 0, 0, 8'h80, 0, 1, 1, 0, 0, 8'h80};
        vt[8] = '{16, 1, 1, 8'h07, 1, 1, 0, 1, 0, 8'h80};

        bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.prescale = 6'd8;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Result pulse lands 1 + P*(10+PAR_EN) cycles after the start-detect cycle.
        for (int i = 0; i < 9; i++) begin
            push_exp(vt[i].dv, vt[i].perr, vt[i].serr, 1'b0, vt[i].pdata,
                     cyc + 1 + vt[i].p * (10 + int'(vt[i].pe)));
            drive_frame(vt[i].p, vt[i].pe, vt[i].pt, vt[i].d, vt[i].pb, vt[i].stp, BIG);
            wait_drain("vector");
            repeat (5) @(negedge CLK);
        end

        // Back-to-back: line low during stop-done is ignored, so frame 2 is
        // detected one cycle after the stop-bit decision.
        c = cyc;
        push_exp(1, 0, 0, 0, 8'h55, c + 1 + 160);
        push_exp(1, 0, 0, 0, 8'hAA, c + 1 + 160 + 1 + 160);
        drive_frame(16, 0, 0, 8'h55, 0, 1, BIG);
        drive_frame(16, 0, 0, 8'hAA, 0, 1, BIG);
        wait_drain("b2b");
        repeat (5) @(negedge CLK);

        // Start glitch: 3 low cycles, all sample points see 1.
        c = cyc;
        bus.prescale = 6'd8;
        push_exp(0, 0, 0, 1, 8'hAA, c + 9);
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        bus.RX_IN = 1'b1;
        repeat (5) @(negedge CLK);
        chk("glitch_en_at_edge7", int'(bus.edge_cnt_en), 1);
        @(negedge CLK);
        chk("glitch_edge_en_after", int'(bus.edge_cnt_en), 0);
        chk("glitch_bit_en_after",  int'(bus.bit_cnt_en),  0);
        wait_drain("glitch");
        push_exp(1, 0, 0, 0, 8'hC3, cyc + 81);
        drive_frame(8, 0, 0, 8'hC3, 0, 1, BIG);
        wait_drain("rearm");
        repeat (5) @(negedge CLK);

        // Reset while receiving data bit 4.
        drive_frame(8, 0, 0, 8'h99, 0, 1, 4 * 8 + 4);
        chk("midframe_bit_count", int'(bus.bit_count), 4);
        RST = 1'b1;
        bus.RX_IN = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        push_exp(1, 0, 0, 0, 8'h7E, cyc + 81);
        drive_frame(8, 0, 0, 8'h7E, 0, 1, BIG);
        wait_drain("post_reset");
        repeat (5) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
